// File: rtl/muldiv_lane_arbiter.sv
// Shares one iterative mul/div unit between the two X-stage issue lanes, older lane first.
// Optional watchdog: define MULDIV_ARB_TIMEOUT_EN to abort a unit that never reports done.
module muldiv_lane_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic [5:0]      alucode0,
  input  logic [XLEN-1:0] op1_0,
  input  logic [XLEN-1:0] op2_0,
  input  logic            req1,
  input  logic [5:0]      alucode1,
  input  logic [XLEN-1:0] op1_1,
  input  logic [XLEN-1:0] op2_1,
  input  logic            hold,
  input  logic            flush,
  output logic            unit_start,
  output logic            unit_abort,
  output logic [5:0]      unit_alucode,
  output logic [XLEN-1:0] unit_op1,
  output logic [XLEN-1:0] unit_op2,
  input  logic            unit_done,
  input  logic [XLEN-1:0] unit_result,
  output logic [XLEN-1:0] result0,
  output logic [XLEN-1:0] result1,
  output logic            busy,
  output logic            timeout_err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN0 = 2'd1;
  localparam logic [1:0] S_RUN1 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            pend1_q, pend1_d;
  logic            start_q, start_d;
  logic            abort_q, abort_d;
  logic [5:0]      ucode_q, ucode_d;
  logic [XLEN-1:0] uop1_q, uop1_d, uop2_q, uop2_d;
  logic [XLEN-1:0] res0_q, res0_d, res1_q, res1_d;
  logic [5:0]      l1code_q;
  logic [XLEN-1:0] l1op1_q, l1op2_q;
  logic            running, tmo_hit, finish;
  logic            capture_l1;

  assign running = (state_q == S_RUN0) || (state_q == S_RUN1);
  assign finish  = unit_done | tmo_hit;

`ifdef MULDIV_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_err_q, tmo_err_d;

  assign tmo_hit = running && !unit_done && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d     = cnt_q;
    tmo_err_d = tmo_err_q | (tmo_hit & ~flush);
    if (start_d)      cnt_d = '0;
    else if (running) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pend1_d    = pend1_q;
    start_d    = 1'b0;
    abort_d    = 1'b0;
    ucode_d    = ucode_q;
    uop1_d     = uop1_q;
    uop2_d     = uop2_q;
    res0_d     = res0_q;
    res1_d     = res1_q;
    capture_l1 = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!hold && !flush) begin
          if (req0) begin
            start_d    = 1'b1;
            ucode_d    = alucode0;
            uop1_d     = op1_0;
            uop2_d     = op2_0;
            pend1_d    = req1;
            capture_l1 = 1'b1;
            state_d    = S_RUN0;
          end else if (req1) begin
            start_d = 1'b1;
            ucode_d = alucode1;
            uop1_d  = op1_1;
            uop2_d  = op2_1;
            pend1_d = 1'b0;
            state_d = S_RUN1;
          end
        end
      end
      S_RUN0: begin
        if (finish) begin
          res0_d  = tmo_hit ? '1 : unit_result;
          abort_d = tmo_hit;
          if (pend1_q) begin
            start_d = 1'b1;
            ucode_d = l1code_q;
            uop1_d  = l1op1_q;
            uop2_d  = l1op2_q;
            pend1_d = 1'b0;
            state_d = S_RUN1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN1: begin
        if (finish) begin
          res1_d  = tmo_hit ? '1 : unit_result;
          abort_d = tmo_hit;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything, including a done arriving in the same cycle.
    if (flush) begin
      state_d = S_IDLE;
      pend1_d = 1'b0;
      start_d = 1'b0;
      abort_d = running;
      ucode_d = ucode_q;
      uop1_d  = uop1_q;
      uop2_d  = uop2_q;
      res0_d  = res0_q;
      res1_d  = res1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend1_q <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      ucode_q <= '0;
      uop1_q  <= '0;
      uop2_q  <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      state_q <= state_d;
      pend1_q <= pend1_d;
      start_q <= start_d;
      abort_q <= abort_d;
      ucode_q <= ucode_d;
      uop1_q  <= uop1_d;
      uop2_q  <= uop2_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
    end
  end

  // Lane 1 is stalled while lane 0 runs, so a snapshot at lane 0 start stays valid.
  always_ff @(posedge clk) begin
    if (capture_l1) begin
      l1code_q <= alucode1;
      l1op1_q  <= op1_1;
      l1op2_q  <= op2_1;
    end
  end

  assign busy = ((state_q == S_IDLE) && !hold && !flush && (req0 || req1)) || running;

  assign unit_start   = start_q;
  assign unit_abort   = abort_q;
  assign unit_alucode = ucode_q;
  assign unit_op1     = uop1_q;
  assign unit_op2     = uop2_q;
  assign result0      = res0_q;
  assign result1      = res1_q;
endmodule
